// File: rtl/tib_loader.sv
// Line-edits a console byte stream into the TIB and hands each terminated line to the core.
// One byte per 2 cycles with grant high; rx_ready is low while a write is pending or the line is owned by the core.
module tib_loader #(
    parameter int unsigned TIB    = 'h1000,
    parameter int unsigned TIB_SZ = 'h100,
    parameter int unsigned ASZ    = 17
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rx_valid,
    input  logic [7:0]                i_rx_data,
    output logic                      o_rx_ready,
    output logic                      o_mem_req,
    input  logic                      i_mem_gnt,
    output logic [ASZ-1:0]            o_mem_addr,
    output logic [7:0]                o_mem_data,
    output logic                      o_mem_we,
    output logic                      o_line_rdy,
    output logic [$clog2(TIB_SZ)-1:0] o_line_len,
    output logic                      o_line_ovf,
    input  logic                      i_line_ack
);
    localparam int unsigned LW = $clog2(TIB_SZ);
    localparam logic [LW-1:0] IDX_MAX = LW'(TIB_SZ - 1);
    localparam logic [ASZ-1:0] TIB_A = ASZ'(TIB);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_TERM, S_DONE} state_t;

    state_t         r_state, w_state;
    logic [LW-1:0]  r_idx, w_idx;
    logic [ASZ-1:0] r_addr, w_addr;
    logic [7:0]     r_data, w_data;
    logic           r_rx_ready, r_mem_req;
    logic           r_line_rdy, w_line_rdy;
    logic [LW-1:0]  r_line_len, w_line_len;
    logic           r_line_ovf, w_line_ovf;
    logic           r_last_cr, w_last_cr;

    logic           w_rx_hs, w_mem_hs;
    logic [ASZ-1:0] w_tib_idx;
    logic [7:0]     w_byte;

    assign w_rx_hs   = i_rx_valid && r_rx_ready;
    assign w_mem_hs  = r_mem_req && i_mem_gnt;
    assign w_tib_idx = TIB_A + ASZ'(r_idx);
    // Control bytes with no editing meaning are stored as spaces.
    assign w_byte    = (i_rx_data < 8'h20) ? 8'h20 : i_rx_data;

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_addr     = r_addr;
        w_data     = r_data;
        w_line_rdy = r_line_rdy;
        w_line_len = r_line_len;
        w_line_ovf = r_line_ovf;
        w_last_cr  = r_last_cr;
        case (r_state)
            S_IDLE: begin
                if (w_rx_hs) begin
                    w_last_cr = 1'b0;
                    if (i_rx_data == 8'h0D || (i_rx_data == 8'h0A && !r_last_cr)) begin
                        w_last_cr = (i_rx_data == 8'h0D);
                        w_addr    = w_tib_idx;
                        w_data    = 8'h00;
                        w_state   = S_TERM;
                    end else if (i_rx_data == 8'h0A) begin
                        w_state = S_IDLE;
                    end else if (i_rx_data == 8'h08 || i_rx_data == 8'h7F) begin
                        if (r_idx != '0) w_idx = r_idx - LW'(1);
                    end else if (r_idx != IDX_MAX) begin
                        w_addr  = w_tib_idx;
                        w_data  = w_byte;
                        w_state = S_WR;
                    end else begin
                        w_line_ovf = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (w_mem_hs) begin
                    w_idx   = r_idx + LW'(1);
                    w_state = S_IDLE;
                end
            end
            S_TERM: begin
                if (w_mem_hs) begin
                    w_line_len = r_idx;
                    w_line_rdy = 1'b1;
                    w_state    = S_DONE;
                end
            end
            S_DONE: begin
                if (i_line_ack) begin
                    w_line_rdy = 1'b0;
                    w_idx      = '0;
                    w_line_ovf = 1'b0;
                    w_state    = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they align with r_state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_addr     <= TIB_A;
            r_data     <= 8'h00;
            r_rx_ready <= 1'b0;
            r_mem_req  <= 1'b0;
            r_line_rdy <= 1'b0;
            r_line_len <= '0;
            r_line_ovf <= 1'b0;
            r_last_cr  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_addr     <= w_addr;
            r_data     <= w_data;
            r_rx_ready <= (w_state == S_IDLE);
            r_mem_req  <= (w_state == S_WR) || (w_state == S_TERM);
            r_line_rdy <= w_line_rdy;
            r_line_len <= w_line_len;
            r_line_ovf <= w_line_ovf;
            r_last_cr  <= w_last_cr;
        end
    end

    assign o_rx_ready = r_rx_ready;
    assign o_mem_req  = r_mem_req;
    assign o_mem_we   = r_mem_req;
    assign o_mem_addr = r_addr;
    assign o_mem_data = r_data;
    assign o_line_rdy = r_line_rdy;
    assign o_line_len = r_line_len;
    assign o_line_ovf = r_line_ovf;
endmodule

// File: tb/tb_tib_loader.sv
// Scoreboard bench for tib_loader: expected writes and lines are queued as bytes are sent.
module tb_tib_loader;
    localparam int TIB    = 'h1000;
    localparam int TIB_SZ = 8;
    localparam int ASZ    = 17;
    localparam int LW     = $clog2(TIB_SZ);

    logic           clk = 1'b0;
    logic           i_rst = 1'b0;
    logic           i_rx_valid = 1'b0;
    logic [7:0]     i_rx_data = 8'h00;
    logic           o_rx_ready;
    logic           o_mem_req;
    logic           i_mem_gnt = 1'b1;
    logic [ASZ-1:0] o_mem_addr;
    logic [7:0]     o_mem_data;
    logic           o_mem_we;
    logic           o_line_rdy;
    logic [LW-1:0]  o_line_len;
    logic           o_line_ovf;
    logic           i_line_ack = 1'b0;

    tib_loader #(.TIB(TIB), .TIB_SZ(TIB_SZ), .ASZ(ASZ)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
        .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .o_mem_we(o_mem_we),
        .o_line_rdy(o_line_rdy), .o_line_len(o_line_len), .o_line_ovf(o_line_ovf),
        .i_line_ack(i_line_ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [24:0] exp_wr[$];
    int          exp_ln[$];
    logic [7:0]  mem[logic [ASZ-1:0]];
    int          m_idx = 0;
    bit          m_ovf = 0;
    bit          m_last_cr = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Writes complete on the next rising edge; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (o_mem_req && i_mem_gnt) begin
            logic [24:0] e;
            e = (exp_wr.size() > 0) ? exp_wr.pop_front() : '1;
            chk("wr_addr_data", {o_mem_addr, o_mem_data}, e);
            chk("wr_we", o_mem_we, 1);
            mem[o_mem_addr] = o_mem_data;
        end
    end

    task automatic send(input logic [7:0] b);
        bit term = 0;
        int n = 0;
        if (b == 8'h0D) begin
            m_last_cr = 1;
            term = 1;
        end else if (b == 8'h0A) begin
            term = !m_last_cr;
            m_last_cr = 0;
        end else begin
            m_last_cr = 0;
            if (b == 8'h08 || b == 8'h7F) begin
                if (m_idx > 0) m_idx--;
            end else if (m_idx < TIB_SZ - 1) begin
                exp_wr.push_back({17'(TIB + m_idx), (b < 8'h20) ? 8'h20 : b});
                m_idx++;
            end else begin
                m_ovf = 1;
            end
        end
        if (term) begin
            exp_wr.push_back({17'(TIB + m_idx), 8'h00});
            exp_ln.push_back(m_ovf * 256 + m_idx);
        end
        while (!o_rx_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_rx_ready) chk("rx_ready_timeout", o_rx_ready, 1);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic get_line();
        int n = 0;
        int e;
        while (!o_line_rdy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("line_rdy", o_line_rdy, 1);
        e = (exp_ln.size() > 0) ? exp_ln.pop_front() : 'hFFFF;
        chk("line_len", o_line_len, e % 256);
        chk("line_ovf", o_line_ovf, e / 256);
        chk("rx_ready_done", o_rx_ready, 0);
        i_line_ack = 1'b1;
        @(posedge clk); #1;
        i_line_ack = 1'b0;
        chk("ack_line_rdy", o_line_rdy, 0);
        chk("ack_rx_ready", o_rx_ready, 1);
        chk("ack_line_ovf", o_line_ovf, 0);
        m_idx = 0;
        m_ovf = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, o_rx_ready, 0);
        chk({tag, "_mem_req"}, o_mem_req, 0);
        chk({tag, "_mem_we"}, o_mem_we, 0);
        chk({tag, "_mem_addr"}, o_mem_addr, TIB);
        chk({tag, "_mem_data"}, o_mem_data, 0);
        chk({tag, "_line_rdy"}, o_line_rdy, 0);
        chk({tag, "_line_len"}, o_line_len, 0);
        chk({tag, "_line_ovf"}, o_line_ovf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] tib1 [6];
        logic [ASZ-1:0] a0;
        tib1 = '{8'h31, 8'h20, 8'h32, 8'h20, 8'h2B, 8'h00};

        #12;
        chk_reset_vals("rst");
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        chk("rx_ready_after_rst", o_rx_ready, 1);

        // Basic line
        send_str("1 2 +");
        send(8'h0D);
        get_line();
        for (int i = 0; i < 6; i++) chk($sformatf("tib1[%0d]", i), mem[17'(TIB + i)], tib1[i]);

        // Backspace editing, including BS on an empty line
        send(8'h08);
        send_str("ab");
        send(8'h08);
        send_str("c");
        send(8'h0D);
        get_line();

        // CR LF collapse and empty line
        send(8'h0D);
        get_line();
        send(8'h0A);
        send_str("x");
        send(8'h0D);
        get_line();
        chk("tib_x", mem[17'(TIB)], 8'h78);

        // Overflow with an 8-byte buffer
        send_str("0123456789");
        send(8'h0D);
        get_line();
        chk("ovf_term", mem[17'(TIB + 7)], 8'h00);

        // Grant withheld during a write
        i_mem_gnt = 1'b0;
        a0 = 17'(TIB + m_idx);
        send(8'h41);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", o_mem_req, 1);
            chk("stall_addr", o_mem_addr, a0);
            chk("stall_data", o_mem_data, 8'h41);
            chk("stall_rx_ready", o_rx_ready, 0);
            @(posedge clk); #1;
        end
        i_mem_gnt = 1'b1;
        @(posedge clk); #1;
        chk("req_drop", o_mem_req, 0);
        send(8'h09);
        send(8'h0D);
        get_line();
        chk("tab_space", mem[17'(TIB + 1)], 8'h20);

        // Asynchronous reset while a write is pending
        i_mem_gnt = 1'b0;
        send(8'h42);
        #2;
        i_rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        exp_wr.delete();
        m_idx = 0;
        m_ovf = 0;
        m_last_cr = 0;
        @(posedge clk); #1;
        i_rst = 1'b1;
        i_mem_gnt = 1'b1;
        send_str("Z");
        send(8'h0D);
        get_line();
        chk("post_rst_tib", mem[17'(TIB)], 8'h5A);

        repeat (3) @(posedge clk);
        #1;
        chk("wr_queue_left", exp_wr.size(), 0);
        chk("line_queue_left", exp_ln.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
